// File: rtl/adc_frame_emu_pkg.sv
// Shared types and constants for the TDM ADC frame emulator.
// CRC constants are used only when ADC_FRAME_EMU_CRC_EN is defined.
package adc_frame_emu_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_CONST = 2'd1,
    MODE_ID    = 2'd2,
    MODE_WALK  = 2'd3
  } mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam logic [7:0] CRC_INIT = 8'h00;

  function automatic logic [7:0] crc8_step(
    input logic [7:0] crc,
    input logic       b
  );
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/adc_frame_emu_lane.sv
// One DOUT lane: per-slot word generation and MSB-first shifter.
// Optional CRC-8 trailer when ADC_FRAME_EMU_CRC_EN is defined.
module adc_frame_emu_lane
  import adc_frame_emu_pkg::*;
#(
  parameter int CH_PER_LANE = 1,
  parameter int WORD_W      = 24,
  parameter int LANE_IDX    = 0,
  parameter int SW          = $clog2(CH_PER_LANE + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              first,
  input  logic              ld,
  input  logic              sh,
`ifdef ADC_FRAME_EMU_CRC_EN
  input  logic              ld_crc,
`endif
  input  logic [SW-1:0]     slot,
  input  mode_e             mode,
  input  logic [WORD_W-1:0] cval,
  input  logic [15:0]       f,
  output logic              dout
);

  logic [WORD_W-1:0] sr;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] one;
  logic [31:0]       c;
  logic [31:0]       sum;
  logic [31:0]       amt;
  logic [63:0]       idt;

  always_comb begin
    word = '0;
    one  = WORD_W'(1);
    c    = 32'(LANE_IDX * CH_PER_LANE) + 32'(slot);
    sum  = 32'(f) + c;
    amt  = sum % 32'(WORD_W);
    idt  = (64'(c[7:0]) << (WORD_W - 8))
         | (64'(f) & ((64'd1 << (WORD_W - 8)) - 64'd1));
    unique case (mode)
      MODE_RAMP:  word = WORD_W'(sum);
      MODE_CONST: word = cval;
      MODE_ID:    word = WORD_W'(idt);
      MODE_WALK:  word = one << amt;
    endcase
  end

`ifdef ADC_FRAME_EMU_CRC_EN
  logic [7:0] crc;
  logic [7:0] crc_nxt;

  // CRC absorbs each bit as its period ends
  assign crc_nxt = crc8_step(crc, sr[WORD_W-1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr  <= '0;
      crc <= CRC_INIT;
    end else if (clr) begin
      sr  <= '0;
      crc <= CRC_INIT;
    end else if (ld) begin
      sr  <= word;
      crc <= first ? CRC_INIT : crc_nxt;
    end else if (ld_crc) begin
      sr  <= WORD_W'(crc_nxt) << (WORD_W - 8);
      crc <= crc_nxt;
    end else if (sh) begin
      sr  <= sr << 1;
      crc <= crc_nxt;
    end
  end
`else
  logic unused_first;
  assign unused_first = first;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else if (clr) begin
      sr <= '0;
    end else if (ld) begin
      sr <= word;
    end else if (sh) begin
      sr <= sr << 1;
    end
  end
`endif

  assign dout = sr[WORD_W-1];

endmodule

// File: rtl/adc_frame_emu.sv
// ADS127L18-style TDM ADC output emulator: DCLK, FSYNC, DOUT lanes.
// Define ADC_FRAME_EMU_CRC_EN to append a CRC-8 per lane per frame.
module adc_frame_emu
  import adc_frame_emu_pkg::*;
#(
  parameter int LANES       = 8,
  parameter int CH_PER_LANE = 1,
  parameter int WORD_W      = 24,
  parameter int DCLK_DIV    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [WORD_W-1:0] const_val,
  output logic              dclk,
  output logic              fsync,
  output logic [LANES-1:0]  dout,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

`ifdef ADC_FRAME_EMU_CRC_EN
  localparam int FRAME_BITS = CH_PER_LANE * WORD_W + 8;
`else
  localparam int FRAME_BITS = CH_PER_LANE * WORD_W;
`endif
  localparam int PW  = $clog2(DCLK_DIV);
  localparam int BW  = $clog2(FRAME_BITS + 1);
  localparam int WBW = $clog2(WORD_W);
  localparam int SW  = $clog2(CH_PER_LANE + 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     ph;
  logic [BW-1:0]     bit_cnt;
  logic [WBW-1:0]    wb;
  logic [SW-1:0]     slot;
  mode_e             mode_q;
  logic [WORD_W-1:0] cval_q;
  logic [15:0]       f_q;

  logic go, stop, end_bit, last_bit, word_end;
  logic ld, sh;
`ifdef ADC_FRAME_EMU_CRC_EN
  logic ld_crc;
`endif
  logic [SW-1:0]     ld_slot;
  mode_e             lmode;
  logic [WORD_W-1:0] lcval;
  logic [15:0]       lf;

  always_comb begin
    state_d  = state_q;
    go       = 1'b0;
    stop     = 1'b0;
    end_bit  = (state_q == S_RUN) && (ph == PW'(DCLK_DIV - 1));
    last_bit = end_bit && (bit_cnt == BW'(FRAME_BITS - 1));
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          go      = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (last_bit) begin
          if (enable) begin
            go = 1'b1;
          end else begin
            stop    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  assign word_end = end_bit && !last_bit
                 && (wb == WBW'(WORD_W - 1));
  assign ld = go
           || (word_end && slot != SW'(CH_PER_LANE - 1));
`ifdef ADC_FRAME_EMU_CRC_EN
  assign ld_crc = word_end
               && slot == SW'(CH_PER_LANE - 1);
`endif
  assign sh = end_bit && !last_bit && !word_end;

  // A new frame samples live inputs; later slots use the latched copy
  assign ld_slot = go ? '0 : slot + SW'(1);
  assign lmode   = go ? mode_e'(mode) : mode_q;
  assign lcval   = go ? const_val : cval_q;
  assign lf      = !go ? f_q
                 : (state_q == S_RUN) ? frame_cnt + 16'd1
                 : frame_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ph        <= '0;
      bit_cnt   <= '0;
      wb        <= '0;
      slot      <= '0;
      dclk      <= 1'b0;
      fsync     <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
      mode_q    <= MODE_RAMP;
      cval_q    <= '0;
      f_q       <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == S_RUN);
      if (last_bit) frame_cnt <= frame_cnt + 16'd1;
      if (go) begin
        ph      <= '0;
        bit_cnt <= '0;
        wb      <= '0;
        slot    <= '0;
        dclk    <= 1'b0;
        fsync   <= 1'b1;
        mode_q  <= lmode;
        cval_q  <= lcval;
        f_q     <= lf;
      end else if (stop) begin
        ph      <= '0;
        bit_cnt <= '0;
        wb      <= '0;
        slot    <= '0;
        dclk    <= 1'b0;
        fsync   <= 1'b0;
      end else if (end_bit) begin
        ph      <= '0;
        bit_cnt <= bit_cnt + BW'(1);
        dclk    <= 1'b0;
        fsync   <= 1'b0;
        if (word_end) begin
          wb   <= '0;
          slot <= slot + SW'(1);
        end else begin
          wb <= wb + WBW'(1);
        end
      end else if (state_q == S_RUN) begin
        ph   <= ph + PW'(1);
        dclk <= (ph + PW'(1)) >= PW'(DCLK_DIV / 2);
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    adc_frame_emu_lane #(
      .CH_PER_LANE(CH_PER_LANE),
      .WORD_W     (WORD_W),
      .LANE_IDX   (l)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .clr    (stop),
      .first  (go),
      .ld     (ld),
      .sh     (sh),
`ifdef ADC_FRAME_EMU_CRC_EN
      .ld_crc (ld_crc),
`endif
      .slot   (ld_slot),
      .mode   (lmode),
      .cval   (lcval),
      .f      (lf),
      .dout   (dout[l])
    );
  end

endmodule
